// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and LED aspect constants for traffic_ctrl
package traffic_pkg;

    typedef enum logic [2:0] {
        L_GO   = 3'd0,
        L_WARN = 3'd1,
        AR1    = 3'd2,
        R_GO   = 3'd3,
        R_WARN = 3'd4,
        AR2    = 3'd5,
        NIGHT  = 3'd6
    } state_e;

    // {r,g,b}; yellow is red+green on the RGB LED
    localparam logic [2:0] ASP_RED = 3'b100;
    localparam logic [2:0] ASP_YEL = 3'b110;
    localparam logic [2:0] ASP_GRN = 3'b010;
    localparam logic [2:0] ASP_OFF = 3'b000;

endpackage

// File: rtl/traffic_timebase.sv
// rtl/traffic_timebase.sv - free-running divider producing flash phase and dimming enable
module traffic_timebase #(
    parameter int FLASH_BIT = 24,
    parameter int DIM_LO    = 6,
    parameter int DIM_W     = 4
) (
    input  logic clk,
    input  logic rst,
    output logic flash_ph,
    output logic dim_en
);

    if (DIM_W < 1 || DIM_LO < 0 || DIM_LO + DIM_W - 1 > FLASH_BIT) begin : g_bad_div
        $error("traffic_timebase: dimming field must fit inside the divider");
    end

    logic [FLASH_BIT:0] div_q;
    logic [FLASH_BIT:0] div_d;

    always_comb begin
        div_d = div_q + {{FLASH_BIT{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign flash_ph = div_q[FLASH_BIT];
    assign dim_en   = (div_q[DIM_LO+DIM_W-1:DIM_LO] == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-way junction controller with configurable phases,
// pedestrian requests/acks and flashing-yellow night mode
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int CW        = 8,
    parameter int GREEN_T   = 16,
    parameter int YELLOW_T  = 6,
    parameter int ALLRED_T  = 2,
    parameter int PED_MIN   = 3,
    parameter int FLASH_BIT = 24,
    parameter int DIM_LO    = 6,
    parameter int DIM_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          night,
    input  logic          ped_req_l,
    input  logic          ped_req_r,
    output logic          ped_ack_l,
    output logic          ped_ack_r,
    output logic [2:0]    lled,
    output logic [2:0]    rled,
    output logic [CW-1:0] lcnt,
    output logic [CW-1:0] rcnt,
    output logic          lflash,
    output logic          rflash
);

    if (GREEN_T < 1 || GREEN_T >= 2**CW || YELLOW_T < 1 || YELLOW_T >= 2**CW ||
        ALLRED_T < 1 || ALLRED_T >= 2**CW || PED_MIN < 1 || PED_MIN > GREEN_T) begin : g_bad_dur
        $error("traffic_ctrl: durations must lie in [1, 2^CW) and PED_MIN <= GREEN_T");
    end

    localparam logic [CW-1:0] GREEN_C  = CW'(GREEN_T);
    localparam logic [CW-1:0] YELLOW_C = CW'(YELLOW_T);
    localparam logic [CW-1:0] ALLRED_C = CW'(ALLRED_T);
    localparam logic [CW-1:0] PED_C    = CW'(PED_MIN);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    state_e        state_q, state_d, succ;
    logic [CW-1:0] timer_q, timer_d;
    logic          latch_l_q, latch_l_d, latch_r_q, latch_r_d;
    logic          ack_l_q, ack_l_d, ack_r_q, ack_r_d;
    logic          flash_ph, dim_en;
    logic [2:0]    lasp, rasp;

    traffic_timebase #(
        .FLASH_BIT (FLASH_BIT),
        .DIM_LO    (DIM_LO),
        .DIM_W     (DIM_W)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .flash_ph (flash_ph),
        .dim_en   (dim_en)
    );

    function automatic logic [CW-1:0] dur(input state_e s);
        case (s)
            L_GO, R_GO:     dur = GREEN_C;
            L_WARN, R_WARN: dur = YELLOW_C;
            AR1, AR2:       dur = ALLRED_C;
            default:        dur = '0;
        endcase
    endfunction

    always_comb begin
        case (state_q)
            L_GO:    succ = L_WARN;
            L_WARN:  succ = AR1;
            AR1:     succ = night ? NIGHT : R_GO;
            R_GO:    succ = R_WARN;
            R_WARN:  succ = AR2;
            AR2:     succ = night ? NIGHT : L_GO;
            default: succ = AR2;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        latch_l_d = latch_l_q | ped_req_l;
        latch_r_d = latch_r_q | ped_req_r;
        ack_l_d   = 1'b0;
        ack_r_d   = 1'b0;
        if (state_q == NIGHT) begin
            timer_d   = '0;
            latch_l_d = 1'b0;
            latch_r_d = 1'b0;
            if (!night) begin
                state_d = AR2;
                timer_d = ALLRED_C;
            end
        end else if (state_q == L_GO && latch_l_d && timer_q > PED_C) begin
            // a waiting pedestrian shortens the green, taking priority over tick
            timer_d = PED_C;
        end else if (state_q == R_GO && latch_r_d && timer_q > PED_C) begin
            timer_d = PED_C;
        end else if (tick) begin
            if (timer_q == ONE_C) begin
                state_d = succ;
                timer_d = dur(succ);
                if (succ == R_GO) begin
                    latch_l_d = ped_req_l;
                    ack_l_d   = 1'b1;
                end
                if (succ == L_GO) begin
                    latch_r_d = ped_req_r;
                    ack_r_d   = 1'b1;
                end
            end else begin
                timer_d = timer_q - ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= AR2;
            timer_q   <= ALLRED_C;
            latch_l_q <= 1'b0;
            latch_r_q <= 1'b0;
            ack_l_q   <= 1'b0;
            ack_r_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            latch_l_q <= latch_l_d;
            latch_r_q <= latch_r_d;
            ack_l_q   <= ack_l_d;
            ack_r_q   <= ack_r_d;
        end
    end

    always_comb begin
        lasp = ASP_RED;
        rasp = ASP_RED;
        case (state_q)
            L_GO:    lasp = ASP_GRN;
            L_WARN:  lasp = ASP_YEL;
            R_GO:    rasp = ASP_GRN;
            R_WARN:  rasp = ASP_YEL;
            NIGHT: begin
                lasp = ASP_YEL;
                rasp = ASP_YEL;
            end
            default: begin
                lasp = ASP_RED;
                rasp = ASP_RED;
            end
        endcase
    end

    assign lflash    = (state_q == L_WARN || state_q == NIGHT) ? flash_ph : 1'b1;
    assign rflash    = (state_q == R_WARN || state_q == NIGHT) ? flash_ph : 1'b1;
    assign lled      = lasp & {3{dim_en & lflash}};
    assign rled      = rasp & {3{dim_en & rflash}};
    assign lcnt      = timer_q;
    assign rcnt      = timer_q;
    assign ped_ack_l = ack_l_q;
    assign ped_ack_r = ack_r_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - randomized scoreboard bench for traffic_ctrl against a phase-table model
module tb_traffic_ctrl;

    localparam int CW        = 8;
    localparam int GREEN_T   = 5;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int PED_MIN   = 2;
    localparam int FLASH_BIT = 3;
    localparam int DIM_LO    = 0;
    localparam int DIM_W     = 1;
    localparam int NCYC      = 6000;
    localparam int QUIET     = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          night = 1'b0;
    logic          ped_req_l = 1'b0;
    logic          ped_req_r = 1'b0;
    logic          ped_ack_l, ped_ack_r;
    logic [2:0]    lled, rled;
    logic [CW-1:0] lcnt, rcnt;
    logic          lflash, rflash;

    traffic_ctrl #(
        .CW        (CW),
        .GREEN_T   (GREEN_T),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .PED_MIN   (PED_MIN),
        .FLASH_BIT (FLASH_BIT),
        .DIM_LO    (DIM_LO),
        .DIM_W     (DIM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .night     (night),
        .ped_req_l (ped_req_l),
        .ped_req_r (ped_req_r),
        .ped_ack_l (ped_ack_l),
        .ped_ack_r (ped_ack_r),
        .lled      (lled),
        .rled      (rled),
        .lcnt      (lcnt),
        .rcnt      (rcnt),
        .lflash    (lflash),
        .rflash    (rflash)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    lled;
        logic [2:0]    rled;
        logic [CW-1:0] lcnt;
        logic [CW-1:0] rcnt;
        logic          lflash;
        logic          rflash;
        logic          ack_l;
        logic          ack_r;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done = 1'b0;

    // phase table: 0 L_GO, 1 L_WARN, 2 AR1, 3 R_GO, 4 R_WARN, 5 AR2
    int         dur_tbl[6]  = '{GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T};
    logic [2:0] lasp_tbl[6] = '{3'b010, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] rasp_tbl[6] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b110, 3'b100};

    int ph = 5;
    int rem = ALLRED_T;
    int cyc = 0;
    bit in_night = 1'b0;
    bit lat_l = 1'b0;
    bit lat_r = 1'b0;
    bit m_ack_l = 1'b0;
    bit m_ack_r = 1'b0;

    task automatic model_step();
        bit req_l, req_r;
        if (rst) begin
            ph = 5; rem = ALLRED_T; cyc = 0; in_night = 0;
            lat_l = 0; lat_r = 0; m_ack_l = 0; m_ack_r = 0;
            return;
        end
        cyc = (cyc + 1) % (1 << (FLASH_BIT + 1));
        m_ack_l = 0;
        m_ack_r = 0;
        if (in_night) begin
            lat_l = 0;
            lat_r = 0;
            if (!night) begin
                in_night = 0; ph = 5; rem = ALLRED_T;
            end
            return;
        end
        req_l = lat_l | ped_req_l;
        req_r = lat_r | ped_req_r;
        lat_l = req_l;
        lat_r = req_r;
        if (ph == 0 && req_l && rem > PED_MIN) rem = PED_MIN;
        else if (ph == 3 && req_r && rem > PED_MIN) rem = PED_MIN;
        else if (tick) begin
            if (rem > 1) rem = rem - 1;
            else if ((ph == 2 || ph == 5) && night) in_night = 1;
            else begin
                ph = (ph + 1) % 6;
                rem = dur_tbl[ph];
                if (ph == 3) begin lat_l = ped_req_l; m_ack_l = 1; end
                if (ph == 0) begin lat_r = ped_req_r; m_ack_r = 1; end
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        bit   fbit, dim, lf, rf;
        logic [2:0] la, ra;
        fbit = ((cyc >> FLASH_BIT) % 2) == 1;
        dim  = ((cyc >> DIM_LO) % (1 << DIM_W)) == 0;
        if (in_night) begin
            la = 3'b110; ra = 3'b110; lf = fbit; rf = fbit;
        end else begin
            la = lasp_tbl[ph]; ra = rasp_tbl[ph];
            lf = (ph == 1) ? fbit : 1'b1;
            rf = (ph == 4) ? fbit : 1'b1;
        end
        o.lled   = (dim && lf) ? la : 3'b000;
        o.rled   = (dim && rf) ? ra : 3'b000;
        o.lcnt   = in_night ? '0 : CW'(rem);
        o.rcnt   = o.lcnt;
        o.lflash = lf;
        o.rflash = rf;
        o.ack_l  = m_ack_l;
        o.ack_r  = m_ack_r;
        return o;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            exp_q.push_back(model_obs());
        end
    end

    initial begin
        obs_t got, exp;
        int   ncyc;
        ncyc = 0;
        forever begin
            @(negedge clk);
            if (!done) begin
                got = '{lled, rled, lcnt, rcnt, lflash, rflash, ped_ack_l, ped_ack_r};
                tests++;
                ncyc++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty cycle %0d: no expected entry for observed outputs", ncyc);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        fails++;
                        if (fails <= 20)
                            $display("FAIL outputs cycle %0d: got lled=%b rled=%b cnt=%0d/%0d flash=%b%b ack=%b%b, expected lled=%b rled=%b cnt=%0d/%0d flash=%b%b ack=%b%b",
                                     ncyc, got.lled, got.rled, got.lcnt, got.rcnt, got.lflash, got.rflash,
                                     got.ack_l, got.ack_r, exp.lled, exp.rled, exp.lcnt, exp.rcnt,
                                     exp.lflash, exp.rflash, exp.ack_l, exp.ack_r);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            rst  = (i < 2) || (i > QUIET && $urandom_range(0, 599) == 0);
            tick = (i % 4 == 3);
            if (i > QUIET && $urandom_range(0, 199) == 0) night = ~night;
            ped_req_l = (i > QUIET) && ($urandom_range(0, 29) == 0);
            ped_req_r = (i > QUIET) && ($urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl.md
Name: traffic_ctrl

Overview:
- Parametrised two-way junction controller. Successor to the fixed 44-tick traffic block.
- Adds configurable phase durations, per-side pedestrian requests with an acknowledge, and a night mode (both sides flashing yellow).
- Sits between the board 1 Hz `tick` generator and the RGB LED / seven-segment display drivers.

Parameters:
- CW, 8: countdown output width.
- GREEN_T, 16: green duration in ticks.
- YELLOW_T, 6: yellow duration in ticks.
- ALLRED_T, 2: all-red duration in ticks.
- PED_MIN, 3: green remaining (ticks) once a pedestrian request shortens it.
- FLASH_BIT, 24: divider bit that drives flashing.
- DIM_LO, 6: lowest divider bit of the dimming field.
- DIM_W, 4: dimming field width. LEDs are on 1/2^DIM_W of the time. DIM_W >= 1.

Ports:
- clk in 1: system clock.
- rst in 1: synchronous, active-high reset.
- tick in 1: one-clk pulse per second.
- night in 1: level; requests night mode.
- ped_req_l in 1: pedestrian wants to cross the left road (left to red).
- ped_req_r in 1: same for the right road.
- ped_ack_l out 1: one-clk pulse when the left walk phase starts.
- ped_ack_r out 1: same for the right.
- lled out 3: left aspect {r,g,b}. Yellow = r+g.
- rled out 3: right aspect {r,g,b}. Yellow = r+g.
- lcnt out CW: ticks remaining in the current state, zero-extended.
- rcnt out CW: same value as lcnt.
- lflash out 1: left flash phase (1 when not flashing).
- rflash out 1: right flash phase (1 when not flashing).

Behaviour:
- States and lled/rled aspects (bit2=r, bit1=g, bit0=b, always 0):
  - L_GO: left G, right R.
  - L_WARN: left Y, right R.
  - AR1: both R.
  - R_GO: left R, right G.
  - R_WARN: left R, right Y.
  - AR2: both R.
  - NIGHT: both Y, flashing.
- Transition order: L_GO -> L_WARN -> AR1 -> R_GO -> R_WARN -> AR2 -> L_GO.
- Timer:
  - Loaded with the state's duration on entry.
  - On a clk with tick: timer==1 -> move to the next state and load its duration; otherwise decrement.
  - Every timed state lasts exactly its duration in ticks. Full cycle = 2*(GREEN_T+YELLOW_T+ALLRED_T).
- Reset (sync):
  - state=AR2, timer=ALLRED_T, divider=0, ped latches=0, acks=0.
  - First clk after reset: lled=rled=3'b100, lcnt=rcnt=ALLRED_T.
- Divider: free-running counter, FLASH_BIT+1 bits; wraps silently.
- Dimming gate: dim = (divider[DIM_LO+DIM_W-1:DIM_LO]==0). Each LED bit = aspect & dim & flash.
- Flashing:
  - lflash = divider[FLASH_BIT] in L_WARN and NIGHT, else 1.
  - rflash = divider[FLASH_BIT] in R_WARN and NIGHT, else 1.
- Pedestrian requests:
  - ped_req_x sets a latch (sticky, level or pulse).
  - While in L_GO with latch_l=1 and timer>PED_MIN: timer <= PED_MIN on the next clk, irrespective of tick. If tick coincides, the clamp is applied instead of a decrement.
  - Right side is symmetric (R_GO, latch_r).
  - Entry into R_GO clears latch_l and pulses ped_ack_l for 1 clk. Entry into L_GO clears latch_r and pulses ped_ack_r.
  - A request arriving in the same clk as the clear re-sets the latch (set wins).
  - A request made while its side is already red is held until the next walk entry. No early ack.
- Night mode:
  - night is honoured only at AR1/AR2 expiry: enter NIGHT instead of the next GO.
  - NIGHT: timer=0, lcnt=rcnt=0, ped latches held at 0, no acks.
  - night=0 in NIGHT -> AR2 with timer=ALLRED_T on the next clk (tick not required), then L_GO.
  - Deasserting night before AR expiry has no effect.
- Reset mid-operation returns to the reset state in 1 clk from any state, including NIGHT.
- Elaboration check: every duration >= 1 and < 2^CW, and PED_MIN <= GREEN_T.

Decomposition:
- traffic_pkg holds:
  - the state enum;
  - aspect constants ASP_RED=3'b100, ASP_YEL=3'b110, ASP_GRN=3'b010, ASP_OFF=3'b000.
- One sub-module, traffic_timebase: the divider. It outputs flash_ph and dim_en, parametrised by FLASH_BIT/DIM_LO/DIM_W.

Test Plan (GREEN_T=5, YELLOW_T=2, ALLRED_T=1, PED_MIN=2, FLASH_BIT=3, DIM_W=1; tick every 4 clk):
- Reset -> lled=rled=3'b100, lcnt=1. After 1 tick -> L_GO, lled green-gated, lcnt=5.
- Free run 16 ticks -> state sequence durations 5,2,1,5,2,1. Back in L_GO at tick 17.
- ped_req_l pulse at L_GO lcnt=5 -> next clk lcnt=2. L_WARN 2 ticks later. ped_ack_l pulses once on R_GO entry.
- ped_req_l during R_GO -> no clamp, no ack until the following R_GO. The intervening L_GO is clamped to 2.
- night=1 during L_GO -> full L_WARN and AR1, then NIGHT (lcnt=0, both flashing yellow). night=0 -> AR2 for 1 tick, then L_GO.
- rst pulse mid R_WARN, and tick coincident with the ped clamp -> reset state next clk. The clamp loads exactly 2, not 1.
